vec_stream_tx: RTL and testbench



---
 rtl/vec_tx_pkg.sv | 19 +
 rtl/vec_tx_bank.sv | 32 +++
 rtl/vec_stream_tx.sv | 120 ++++++++++++
 tb/tb_vec_stream_tx.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vec_tx_pkg.sv
// Shared constants and types for the vec_stream_tx serializer.
package vec_tx_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LANES  = 4;
  localparam int LANE_W     = $clog2(DEF_LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND_A = 2'd1,
    SEND_B = 2'd2,
    SEND_D = 2'd3
  } send_state_t;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] a;
    logic signed [DEF_DATA_W-1:0] b;
    logic signed [DEF_DATA_W-1:0] d;
  } tuple_t;
endpackage

// File: rtl/vec_tx_bank.sv
// LANES-entry tuple register bank: writes land at the running index, full once all lanes are loaded.
module vec_tx_bank
  import vec_tx_pkg::*;
#(
  parameter int LANES = DEF_LANES
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   wr_en,
  input  logic   clr,
  input  tuple_t wr_data,
  output tuple_t entries [LANES],
  output logic   full
);
  localparam int IW = $clog2(LANES);

  logic [IW:0] cnt;

  assign full = (cnt == (IW+1)'(LANES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < LANES; i++) entries[i] <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (wr_en && !full) begin
      entries[cnt[IW-1:0]] <= wr_data;
      cnt                  <= cnt + (IW+1)'(1);
    end
  end
endmodule

// File: rtl/vec_stream_tx.sv
// Double-buffered tuple-to-byte serializer emitting frames of all a, then all b, then all d.
// Optional completed-frame counter port frames_sent enabled by VEC_TX_FRAME_CNT_EN.
//   state  | meaning
//   IDLE   | nothing on dout, waiting for a full fill bank
//   SEND_A | dout carries a[lane]
//   SEND_B | dout carries b[lane]
//   SEND_D | dout carries d[lane]; a full bank at the last lane chains straight into SEND_A
module vec_stream_tx
  import vec_tx_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic signed [DATA_W-1:0] in_d,
  output logic signed [DATA_W-1:0] dout,
  output logic                     dout_valid,
  output logic                     frame_start
`ifdef VEC_TX_FRAME_CNT_EN
  ,
  output logic [15:0]              frames_sent
`endif
);
  localparam int LW = $clog2(LANES);

  tuple_t      fill_bank [LANES];
  tuple_t      send_bank [LANES];
  tuple_t      in_tuple;
  logic        full;
  send_state_t state;
  logic [LW-1:0] lane, lane_nxt;
  logic        last_lane, xfer;

  assign in_tuple  = '{a: in_a, b: in_b, d: in_d};
  assign in_ready  = ~full;
  assign last_lane = (lane == LW'(LANES - 1));
  assign lane_nxt  = lane + LW'(1);
  assign xfer      = full && ((state == IDLE) || ((state == SEND_D) && last_lane));

  vec_tx_bank #(.LANES(LANES)) u_fill (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid && in_ready),
    .clr     (xfer),
    .wr_data (in_tuple),
    .entries (fill_bank),
    .full    (full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lane        <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      for (int i = 0; i < LANES; i++) send_bank[i] <= '0;
    end else if (xfer) begin
      // the new frame's a[0] comes straight from the fill bank while it is copied
      send_bank   <= fill_bank;
      state       <= SEND_A;
      lane        <= '0;
      dout        <= fill_bank[0].a;
      dout_valid  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          dout       <= '0;
          dout_valid <= 1'b0;
        end
        SEND_A: begin
          if (last_lane) begin
            state <= SEND_B;
            lane  <= '0;
            dout  <= send_bank[0].b;
          end else begin
            lane <= lane_nxt;
            dout <= send_bank[lane_nxt].a;
          end
        end
        SEND_B: begin
          if (last_lane) begin
            state <= SEND_D;
            lane  <= '0;
            dout  <= send_bank[0].d;
          end else begin
            lane <= lane_nxt;
            dout <= send_bank[lane_nxt].b;
          end
        end
        SEND_D: begin
          if (last_lane) begin
            state      <= IDLE;
            lane       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
          end else begin
            lane <= lane_nxt;
            dout <= send_bank[lane_nxt].d;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef VEC_TX_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              frames_sent <= '0;
    else if ((state == SEND_D) && last_lane) frames_sent <= frames_sent + 16'd1;
  end
`endif
endmodule

// File: tb/tb_vec_stream_tx.sv
// Self-checking bench for vec_stream_tx: directed cases plus random traffic against a frame-level model.
module tb_vec_stream_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_a, in_b, in_d;
  logic signed [7:0] dout;
  logic              dout_valid;
  logic              frame_start;
`ifdef VEC_TX_FRAME_CNT_EN
  logic [15:0]       frames_sent;
`endif

  vec_stream_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_d        (in_d),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .frame_start (frame_start)
`ifdef VEC_TX_FRAME_CNT_EN
    ,
    .frames_sent (frames_sent)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // model: expected byte per sample index, frame starts/ends, pending tuples
  logic [7:0] exp_d  [int];
  bit         fs_at  [int];
  bit         end_at [int];
  logic [7:0] qa[$], qb[$], qd[$];
  int last_end   = 0;
  int full_until = 0;
  int last_start = 0;
  int fcnt       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit ready_m();
    return cyc >= full_until;
  endfunction

  task automatic model_reset();
    exp_d.delete();
    fs_at.delete();
    end_at.delete();
    qa.delete(); qb.delete(); qd.delete();
    last_end   = 0;
    full_until = 0;
    fcnt       = 0;
  endtask

  task automatic check_sample();
    logic [7:0] eb;
    bit ev;
    ev = exp_d.exists(cyc);
    eb = ev ? exp_d[cyc] : 8'h00;
    chk("dout", {24'h0, dout}, {24'h0, eb});
    chk("dout_valid", {31'h0, dout_valid}, {31'h0, ev});
    chk("frame_start", {31'h0, frame_start}, {31'h0, fs_at.exists(cyc)});
    chk("in_ready", {31'h0, in_ready}, {31'h0, ready_m()});
`ifdef VEC_TX_FRAME_CNT_EN
    if (end_at.exists(cyc)) fcnt = (fcnt + 1) & 16'hFFFF;
    chk("frames_sent", {16'h0, frames_sent}, fcnt);
`endif
  endtask

  // one clock: check current sample, drive inputs, update model, advance to next negedge
  task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] d,
                       output bit acc);
    int start;
    check_sample();
    in_valid = v;
    in_a = a; in_b = b; in_d = d;
    acc = v && ready_m() && rst_n;
    if (acc) begin
      qa.push_back(a); qb.push_back(b); qd.push_back(d);
      if (qa.size() == 4) begin
        start = (cyc + 2 > last_end) ? cyc + 2 : last_end;
        for (int i = 0; i < 4; i++) begin
          exp_d[start + i]     = qa[i];
          exp_d[start + 4 + i] = qb[i];
          exp_d[start + 8 + i] = qd[i];
        end
        fs_at[start]       = 1'b1;
        end_at[start + 12] = 1'b1;
        last_start = start;
        last_end   = start + 12;
        full_until = start;
        qa.delete(); qb.delete(); qd.delete();
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 8'h00, acc);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] d);
    bit acc;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, a, b, d, acc);
      if (acc) return;
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit acc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0; in_b = '0; in_d = '0;
    model_reset();
    @(negedge clk);
    chk("rst_dout", {24'h0, dout}, 32'h0);
    chk("rst_valid", {31'h0, dout_valid}, 32'h0);
    chk("rst_fs", {31'h0, frame_start}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h1);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // directed frame with extremes
    send(8'h7F, 8'h80, 8'h00);
    send(8'h80, 8'h7F, 8'h00);
    send(8'h00, 8'h7F, 8'h10);
    send(8'h7F, 8'h00, 8'h20);
    idle(20);

    // eight tuples back-to-back: two chained frames
    for (int i = 0; i < 8; i++) send(8'(i * 3 + 1), 8'(8'hF0 + i), 8'(8'h40 - i));
    idle(35);

    // three tuples, long pause, fourth
    for (int i = 0; i < 3; i++) send(8'(i + 5), 8'(i + 9), 8'(i + 13));
    idle(10);
    send(8'h55, 8'hAA, 8'h33);
    idle(20);

    // boundary values in every lane
    for (int i = 0; i < 4; i++) send(8'hFF, 8'h80, 8'h7F);
    idle(20);

    // reset in the middle of SEND_B
    for (int i = 0; i < 4; i++) send(8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i));
    for (int i = 0; i < 64 && cyc < last_start + 5; i++) idle(1);
    chk("reached_send_b", cyc, last_start + 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", {24'h0, dout}, 32'h0);
    chk("midrst_valid", {31'h0, dout_valid}, 32'h0);
    chk("midrst_ready", {31'h0, in_ready}, 32'h1);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 8'(8'h11 * i), 8'(8'h70 - i));
    idle(20);

    // random traffic
    for (int i = 0; i < 500; i++)
      cycle(($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            8'($urandom_range(0, 255)), acc);
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
